// File: rtl/adsr_envelope_pkg.sv
// Shared constants for the ADSR envelope / VCA stage: state encoding and default widths.
package adsr_envelope_pkg;

    localparam int SAMPLE_WIDTH = 24;
    localparam int ENV_BITS     = 16;
    localparam int VEL_BITS     = 7;
    localparam int SUS_BITS     = 8;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/adsr_envelope_if.sv
// Audio sample stream into and out of the envelope VCA (strobed, no backpressure).
interface adsr_envelope_if #(
    parameter int SAMPLE_WIDTH = 24
);
    logic signed [SAMPLE_WIDTH-1:0] sample_in;
    logic                           sample_valid_in;
    logic signed [SAMPLE_WIDTH-1:0] sample_out;
    logic                           valid_out;

    modport master (
        output sample_in, sample_valid_in,
        input  sample_out, valid_out
    );

    modport slave (
        input  sample_in, sample_valid_in,
        output sample_out, valid_out
    );
endinterface

// File: rtl/adsr_envelope_env_vca.sv
// Registered signed x unsigned envelope scaler with a one-cycle valid pipe.
module env_vca #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int ENV_BITS     = 16
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [ENV_BITS-1:0] env_i,
    adsr_envelope_if.slave      audio_if
);
    logic signed [SAMPLE_WIDTH+ENV_BITS:0] product;
    logic signed [SAMPLE_WIDTH-1:0]        sample_q;
    logic                                  valid_q;
    logic                                  unused_bits;

    // Zero-extended env keeps the scale factor positive; dropping the low
    // ENV_BITS of a two's-complement product floors toward -inf.
    assign product     = audio_if.sample_in * $signed({1'b0, env_i});
    assign unused_bits = ^{product[SAMPLE_WIDTH+ENV_BITS], product[ENV_BITS-1:0]};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= audio_if.sample_valid_in;
            if (audio_if.sample_valid_in) begin
                sample_q <= product[SAMPLE_WIDTH+ENV_BITS-1:ENV_BITS];
            end
        end
    end

    assign audio_if.sample_out = sample_q;
    assign audio_if.valid_out  = valid_q;
endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator: gate/velocity FSM, per-tick step arithmetic,
// and the VCA that scales the carrier sample by the current envelope.
module adsr_envelope #(
    parameter int SAMPLE_WIDTH = adsr_envelope_pkg::SAMPLE_WIDTH,
    parameter int ENV_BITS     = adsr_envelope_pkg::ENV_BITS
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                tick_in,
    input  logic                gate_in,
    input  logic [6:0]          velocity_in,
    input  logic [ENV_BITS-1:0] attack_in,
    input  logic [ENV_BITS-1:0] decay_in,
    input  logic [ENV_BITS-1:0] release_in,
    input  logic [7:0]          sustain_in,
    adsr_envelope_if.slave      audio_if,
    output logic [ENV_BITS-1:0] env_out,
    output logic [2:0]          state_out,
    output logic                busy_out
);
    import adsr_envelope_pkg::*;

    env_state_t          state_q, state_d;
    logic [ENV_BITS-1:0] env_q, env_d;
    logic [ENV_BITS-1:0] peak_q, peak_d;
    logic                gate_q;

    logic                gate_on, gate_rise, gate_fall;
    logic [ENV_BITS-1:0] new_peak;
    logic [ENV_BITS+7:0] sus_prod;
    logic [ENV_BITS-1:0] sus_level;
    logic [ENV_BITS:0]   att_sum, dec_floor;
    logic                unused_bits;

    // Velocity 0 with the gate held is a note-off.
    assign gate_on   = gate_in & (velocity_in != '0);
    assign gate_rise = gate_on & ~gate_q;
    assign gate_fall = ~gate_on & gate_q;

    assign new_peak    = {velocity_in, {(ENV_BITS-7){1'b1}}};
    assign sus_prod    = {8'b0, peak_q} * {{ENV_BITS{1'b0}}, sustain_in};
    assign sus_level   = sus_prod[ENV_BITS+7:8];
    assign unused_bits = ^sus_prod[7:0];

    // One bit of headroom; "env - decay <= sus" is tested as "env <= sus + decay"
    // so the subtraction never has to go negative.
    assign att_sum   = {1'b0, env_q} + {1'b0, attack_in};
    assign dec_floor = {1'b0, sus_level} + {1'b0, decay_in};

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        peak_d  = peak_q;

        if (gate_rise) begin
            peak_d  = new_peak;
            state_d = ENV_ATTACK;
        end else if (gate_fall) begin
            if (state_q inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN}) begin
                state_d = ENV_RELEASE;
            end
        end else if (tick_in) begin
            case (state_q)
                ENV_IDLE: env_d = '0;
                ENV_ATTACK: begin
                    if (attack_in == '0 || att_sum >= {1'b0, peak_q}) begin
                        env_d   = peak_q;
                        state_d = ENV_DECAY;
                    end else begin
                        env_d = att_sum[ENV_BITS-1:0];
                    end
                end
                ENV_DECAY: begin
                    if (decay_in == '0 || {1'b0, env_q} <= dec_floor) begin
                        env_d   = sus_level;
                        state_d = ENV_SUSTAIN;
                    end else begin
                        env_d = env_q - decay_in;
                    end
                end
                ENV_SUSTAIN: env_d = sus_level;
                ENV_RELEASE: begin
                    if (release_in == '0 || env_q <= release_in) begin
                        env_d   = '0;
                        state_d = ENV_IDLE;
                    end else begin
                        env_d = env_q - release_in;
                    end
                end
                default: begin
                    env_d   = '0;
                    state_d = ENV_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ENV_IDLE;
            env_q   <= '0;
            peak_q  <= '0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            peak_q  <= peak_d;
            gate_q  <= gate_on;
        end
    end

    env_vca #(
        .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .ENV_BITS    (ENV_BITS)
    ) u_vca (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .env_i   (env_q),
        .audio_if(audio_if)
    );

    assign env_out   = env_q;
    assign state_out = state_q;
    assign busy_out  = (state_q != ENV_IDLE);
endmodule
